// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage and the decode/control block:
// opcodes, the NOP word, fetch FSM states and the IF/ID payload.
package fetch_stage_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_SLA = 4'h6,
        OP_SRA = 4'h7,
        OP_LI  = 4'h8,
        OP_LW  = 4'h9,
        OP_SW  = 4'hA,
        OP_BIZ = 4'hB,
        OP_BNZ = 4'hC,
        OP_JAL = 4'hD,
        OP_JR  = 4'hE,
        OP_HLT = 4'hF   // RESET/HLT share the top opcode
    } opcode_e;

    localparam logic [15:0] INSTR_NOP = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc1;
    } ifid_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer holding a cache response that arrived while decode stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  ifid_entry_t din,
    output logic        full,
    output ifid_entry_t dout
);

    logic        full_q, full_d;
    ifid_entry_t data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = din;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, I-cache request handshake, IF/ID register, stall skid,
// miss drain before redirect, and HLT stop.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = INSTR_NOP,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_rdy,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc1,
    output logic        ifid_valid,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pend_q, pend_d;
    ifid_entry_t  ifid_q, ifid_d;
    logic         valid_q, valid_d;

    logic         skid_load, skid_unload, skid_flush, skid_full;
    ifid_entry_t  skid_din, skid_dout;
    logic [15:0]  pc_inc;
    logic         data_hlt, skid_hlt;

    assign pc_inc   = pc_q + 16'd1;
    assign skid_din = '{instr: imem_data, pc1: pc_inc};
    assign data_hlt = (imem_data[15:12] == HLT_OPCODE);
    assign skid_hlt = (skid_dout.instr[15:12] == HLT_OPCODE);

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .din    (skid_din),
        .full   (skid_full),
        .dout   (skid_dout)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        ifid_d      = ifid_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    ifid_d.instr = NOP_INSTR;
                    valid_d      = 1'b0;
                    skid_flush   = 1'b1;
                    // An outstanding miss must complete before the new address is issued
                    if (imem_rdy) begin
                        pc_d = redirect_pc;
                    end else begin
                        pend_d  = redirect_pc;
                        state_d = DRAIN;
                    end
                end else if (stall) begin
                    if (imem_rdy && !skid_full) begin
                        skid_load = 1'b1;
                        pc_d      = pc_inc;
                    end
                end else if (skid_full) begin
                    ifid_d      = skid_dout;
                    valid_d     = 1'b1;
                    skid_unload = 1'b1;
                    if (skid_hlt) state_d = HALT;
                end else if (imem_rdy) begin
                    ifid_d  = '{instr: imem_data, pc1: pc_inc};
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    if (data_hlt) state_d = HALT;
                end else begin
                    ifid_d.instr = NOP_INSTR;
                    valid_d      = 1'b0;
                end
            end
            DRAIN: begin
                ifid_d.instr = NOP_INSTR;
                valid_d      = 1'b0;
                if (redirect) pend_d = redirect_pc;
                if (imem_rdy) begin
                    pc_d    = redirect ? redirect_pc : pend_q;
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    state_d      = FETCH;
                    ifid_d.instr = NOP_INSTR;
                    valid_d      = 1'b0;
                end else if (!stall) begin
                    ifid_d.instr = NOP_INSTR;
                    valid_d      = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            ifid_q  <= '{instr: NOP_INSTR, pc1: 16'h0000};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            ifid_q  <= ifid_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req   = (state_q != HALT);
    assign imem_addr  = pc_q;
    assign halted     = (state_q == HALT);
    assign ifid_instr = ifid_q.instr;
    assign ifid_pc1   = ifid_q.pc1;
    assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the main scenarios, then
// random stall/redirect/miss/reset traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk, rst, stall, redirect, imem_req, imem_rdy, ifid_valid, halted;
    logic [15:0] redirect_pc, imem_addr, imem_data, ifid_instr, ifid_pc1;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_rdy   (imem_rdy),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = fetching, 1 = draining a miss, 2 = halted
    int          m_mode = 0;
    logic [15:0] m_pc = 16'h0, m_pend = 16'h0, m_instr = 16'h0, m_pc1 = 16'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_skid[$];
    bit          hlt_at3 = 1'b0;
    bit          cmp_en  = 1'b0;

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (hlt_at3 && a == 16'd3) return 16'hF000;
        return 16'h1000 + a;
    endfunction

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic bubble();
        m_instr = 16'h0000;
        m_valid = 1'b0;
    endtask

    task automatic take(input logic [15:0] w, input logic [15:0] p1);
        m_instr = w;
        m_pc1   = p1;
        m_valid = 1'b1;
        if (w[15:12] == 4'hF) m_mode = 2;
    endtask

    // Predict the state after the coming clock edge from the spec's rules.
    task automatic step(input bit r, input bit st, input bit rd, input logic [15:0] rpc,
                        input bit rdy, input logic [15:0] d);
        logic [31:0] w;
        if (!r) begin
            m_pc = 16'h0; m_mode = 0; m_skid.delete();
            m_instr = 16'h0; m_pc1 = 16'h0; m_valid = 1'b0;
            return;
        end
        if (m_mode == 0) begin
            if (rd) begin
                bubble();
                m_skid.delete();
                if (rdy) m_pc = rpc;
                else begin m_pend = rpc; m_mode = 1; end
            end else if (st) begin
                if (rdy && m_skid.size() == 0) begin
                    m_skid.push_back({d, m_pc + 16'd1});
                    m_pc = m_pc + 16'd1;
                end
            end else if (m_skid.size() != 0) begin
                w = m_skid.pop_front();
                take(w[31:16], w[15:0]);
            end else if (rdy) begin
                take(d, m_pc + 16'd1);
                m_pc = m_pc + 16'd1;
            end else begin
                bubble();
            end
        end else if (m_mode == 1) begin
            bubble();
            if (rd) m_pend = rpc;
            if (rdy) begin m_pc = m_pend; m_mode = 0; end
        end else begin
            if (rd) begin m_pc = rpc; m_mode = 0; bubble(); end
            else if (!st) bubble();
        end
    endtask

    // One cycle: drive inputs at negedge, advance the model, wait for next negedge.
    task automatic cyc(input bit r, input bit st, input bit rd, input logic [15:0] rpc, input bit rdy);
        logic [15:0] d;
        d = rdy ? mem(m_pc) : 16'($urandom);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc;
        imem_rdy = rdy; imem_data = d;
        step(r, st, rd, rpc, rdy, d);
        cmp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic hit();
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk1("ifid_valid", ifid_valid, m_valid);
            chk16("ifid_instr", ifid_instr, m_instr);
            if (m_valid) chk16("ifid_pc1", ifid_pc1, m_pc1);
            chk1("imem_req", imem_req, m_mode != 2);
            chk1("halted", halted, m_mode == 2);
            if (m_mode != 2) chk16("imem_addr", imem_addr, m_pc);
        end
    end

    initial begin
        // reset state
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk1("rst_valid", ifid_valid, 1'b0);
        chk16("rst_instr", ifid_instr, 16'h0000);
        chk16("rst_pc1", ifid_pc1, 16'h0000);
        chk16("rst_addr", imem_addr, 16'h0000);
        chk1("rst_halted", halted, 1'b0);

        // back-to-back hits
        hit(); chk16("seq0", ifid_instr, 16'h1000); chk16("seq0_pc1", ifid_pc1, 16'h0001);
        chk1("seq0_v", ifid_valid, 1'b1);
        hit(); chk16("seq1", ifid_instr, 16'h1001); chk16("seq1_pc1", ifid_pc1, 16'h0002);
        hit(); chk16("seq2", ifid_instr, 16'h1002); chk16("seq2_pc1", ifid_pc1, 16'h0003);
        hit();

        // stall 3 cycles at pc=4: skid captures 1004
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        chk16("stall_hold", ifid_instr, 16'h1003);
        hit(); chk16("skid_out", ifid_instr, 16'h1004); chk16("skid_pc1", ifid_pc1, 16'h0005);
        hit(); chk16("after_skid", ifid_instr, 16'h1005);
        hit(); hit();

        // 4-cycle miss at pc=8 with redirect on the 2nd miss cycle
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0); chk16("miss_addr1", imem_addr, 16'h0008);
        cyc(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0); chk16("miss_addr2", imem_addr, 16'h0008);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0); chk16("miss_addr3", imem_addr, 16'h0008);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk1("drain_discard", ifid_valid, 1'b0); chk16("drain_next", imem_addr, 16'h0040);
        hit(); chk16("redir_instr", ifid_instr, 16'h1040); chk16("redir_pc1", ifid_pc1, 16'h0041);

        // redirect + stall with skid full
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'h0020, 1'b1); chk1("rs_bubble", ifid_valid, 1'b0);
        hit(); chk16("rs_instr", ifid_instr, 16'h1020); chk16("rs_pc1", ifid_pc1, 16'h0021);

        // HLT at address 3
        hlt_at3 = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
        hit(); hit(); hit(); hit();
        chk16("hlt_word", ifid_instr, 16'hF000); chk1("hlt_halted", halted, 1'b1);
        chk1("hlt_req", imem_req, 1'b0);
        hit(); chk1("hlt_bubble", ifid_valid, 1'b0); chk1("hlt_stays", halted, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'h0010, 1'b1);
        chk1("resume_halted", halted, 1'b0); chk16("resume_addr", imem_addr, 16'h0010);
        hit(); chk16("resume_instr", ifid_instr, 16'h1010);
        hlt_at3 = 1'b0;

        // pc wrap
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        hit(); chk16("wrap_instr", ifid_instr, 16'h0FFF); chk16("wrap_pc1", ifid_pc1, 16'h0000);
        chk16("wrap_addr", imem_addr, 16'h0000);
        hit(); chk16("wrap_next_pc1", ifid_pc1, 16'h0001);

        // reset in the middle of a drain
        cyc(1'b1, 1'b0, 1'b1, 16'h0123, 1'b0); chk16("pre_rst_addr", imem_addr, 16'h0001);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk1("mrst_valid", ifid_valid, 1'b0); chk16("mrst_instr", ifid_instr, 16'h0000);
        chk16("mrst_pc1", ifid_pc1, 16'h0000); chk16("mrst_addr", imem_addr, 16'h0000);
        chk1("mrst_req", imem_req, 1'b1); chk1("mrst_halted", halted, 1'b0);

        // random traffic
        hlt_at3 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit r, st, rd, rdy;
            logic [15:0] rpc;
            r   = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = ($urandom_range(0, 9) < 7) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            cyc(r, st, rd, rpc, rdy);
        end

        cmp_en = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
